mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter sharing the single RAM port between the instruction-fetch path (icache/fetch stage) and the data path (dcache/MEM stage) of the pipelined processor. It grants one access at a time, latches the granted address/data, and holds it stable on the RAM port until the RAM reports completion. It returns the result to the granted requester with a one-cycle wait release. Data accesses have priority; a starvation counter guarantees instruction fetch forward progress.

## Interface
- ADDR_W, 32, address width of both requesters and the RAM port
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants taken while iREN is pending before instruction gets forced priority (1..15)

- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  low for exactly the completion cycle of an instruction access
- iload  out  DATA_W  instruction data, valid when iwait low
- dREN  in  1  data read request
- dWEN  in  1  data write request (wins over dREN if both high)
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  low for exactly the completion cycle of a data access
- dload  out  DATA_W  read data, valid when dwait low
- ierr, derr  out  1  error flag, valid only in the respective completion cycle
- ramREN, ramWEN  out  1  RAM read/write strobes (registered)
- ramaddr  out  ADDR_W  RAM address (registered)
- ramstore  out  DATA_W  RAM write data (registered)
- ramload  in  DATA_W  RAM read data
- ram_ready  in  1  RAM completes current access this cycle
- ram_error  in  1  RAM completes current access with error this cycle

## Operation
- States: IDLE, IACC, DACC.
- IDLE: if no request, stay. Otherwise grant:
  - data only -> DACC; instr only -> IACC;
  - both -> IACC if starve_cnt == STARVE_MAX, else DACC.
- On grant, register ramaddr/ramstore/ramREN/ramWEN from the winner's inputs. Data write: ramWEN=1, ramREN=0. Data read and instruction: ramREN=1.
- IACC/DACC: hold all RAM outputs stable. On ram_ready or ram_error, complete:
  - drop the granted wait low;
  - drive iload/dload = ramload;
  - drive ierr/derr = ram_error;
  - clear the strobes;
  - return to IDLE.
  If both ram_ready and ram_error are high, the access is an error.
- Mandatory IDLE cycle after every completion, so a requester still asserting on its completion cycle is never re-granted.
- starve_cnt (4 bits, saturating at STARVE_MAX):
  - +1 on each DACC grant while iREN is high;
  - cleared on any IACC grant;
  - cleared on a DACC grant with iREN low.
- Request withdrawn mid-access: the access runs to completion. Wait still pulses low; the requester ignores it.
- Inputs other than those of the winner are ignored during IACC/DACC.
- iload/dload outputs ramload combinationally in all cycles; they are meaningful only when the corresponding wait is low.

## Timing
- Reset (async, nRST low): state=IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, starve_cnt=0, iwait=1, dwait=1, ierr=0, derr=0. An access in flight is abandoned.
- Request sampled in IDLE at edge N; RAM strobes are visible after edge N.
- Completion: iwait/dwait/err are combinational from state and ram_ready/ram_error in the same cycle. ram_ready seen in cycle M gives wait low in cycle M and IDLE after edge M.
- Minimum access latency, request to wait low: 2 cycles (ram_ready high on the first access cycle).
- Back-to-back throughput: one access per (RAM latency + 1) cycles.
- iwait and dwait are never low in the same cycle. ramREN and ramWEN are never both high.

## Test plan
- After reset: iREN=1, iaddr=0x40, ram_ready high on the first IACC cycle -> ramREN=1 and ramaddr=0x40 one cycle after the request; iwait low with iload=ramload in cycle 2; IDLE in cycle 3.
- Simultaneous iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF) -> DACC first with ramWEN=1, ramstore=0xDEADBEEF; IACC granted in the IDLE cycle after dwait pulses.
- iREN held high with dREN re-asserted every IDLE, STARVE_MAX=4 -> exactly 4 data grants, then the 5th grant is IACC and starve_cnt returns to 0.
- RAM latency 5 cycles, with daddr/dstore and iREN toggled during DACC -> ramaddr/ramstore are constant for all 5 cycles; dwait is low only on the 5th cycle.
- ram_error on an instruction access -> iwait low and ierr=1 for one cycle; derr=0; IDLE next cycle.
- nRST pulsed low mid-DACC -> strobes drop to 0 immediately (asynchronously), state=IDLE, dwait=1, starve_cnt=0; a new request after release is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access.
// Data wins contention unless instruction fetch has been passed over
// STARVE_MAX times in a row. The granted address and data are latched and held
// on the RAM port until the RAM completes. Every completion is followed by one
// IDLE cycle.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction requester
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              ierr,
  // data requester
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              derr,
  // RAM port
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  input  logic              ram_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_store_q, ram_store_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;

  logic d_req;
  logic i_forced;
  logic done;

  assign d_req    = dREN | dWEN;
  assign i_forced = iREN && (starve_cnt_q == STARVE_LIM);
  // An error completes the access even without ram_ready.
  assign done     = ram_ready | ram_error;

  // Next state: grant in IDLE, hold the RAM port while busy, release on completion.
  always_comb begin
    // NOTE: every _d defaults to its _q, so no branch can leave a latch behind.
    state_d      = state_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_store_d  = ram_store_q;
    starve_cnt_d = starve_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d     = DACC;
          ram_addr_d  = daddr;
          ram_store_d = dstore;
          ram_wen_d   = dWEN;
          ram_ren_d   = !dWEN;
          // Count only grants that made a waiting fetch lose.
          if (!iREN) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (iREN) begin
          state_d      = IACC;
          ram_addr_d   = iaddr;
          ram_ren_d    = 1'b1;
          ram_wen_d    = 1'b0;
          starve_cnt_d = 4'd0;
        end
      end
      IACC, DACC: begin
        if (done) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  // State and registered RAM-port outputs; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q      <= state_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_store_q  <= ram_store_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;

  // Completion flags are combinational, so wait drops in the cycle the RAM finishes.
  assign iwait = !((state_q == IACC) && done);
  assign dwait = !((state_q == DACC) && done);
  assign ierr  = (state_q == IACC) && ram_error;
  assign derr  = (state_q == DACC) && ram_error;

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic scored against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              iREN, dREN, dWEN;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [DATA_W-1:0] dstore, ramload;
  logic              ram_ready, ram_error;
  logic              iwait, dwait, ierr, derr;
  logic [DATA_W-1:0] iload, dload, ramstore;
  logic              ramREN, ramWEN;
  logic [ADDR_W-1:0] ramaddr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ram_mem [16];
  logic [31:0] ref_mem [16];

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload), .ierr(ierr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .derr(derr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .ram_error(ram_error)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs are driven just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ram_ready = 0; ram_error = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  // Hold iREN and dREN high with a one-cycle RAM and expect the grant pattern D,D,D,D,I repeated.
  task automatic observe_contention(input string tag);
    int seen = 0;
    logic exp_i;
    iREN = 1; dREN = 1; dWEN = 0; ram_ready = 1; ram_error = 0;
    iaddr = 32'h0000_1000; daddr = 32'h0000_2000;
    for (int cyc = 0; cyc < 40 && seen < 10; cyc++) begin
      settle();
      if (!iwait || !dwait) begin
        exp_i = ((seen % 5) == 4);
        n_checks++;
        if ({!iwait, !dwait} !== {exp_i, !exp_i})
          $display("FAIL %s_grant%0d: i_done/d_done=%b%b want %b%b",
                   tag, seen, !iwait, !dwait, exp_i, !exp_i);
        else n_pass++;
        seen++;
      end
      next_cycle();
    end
    n_checks++;
    if (seen != 10) $display("FAIL %s_count: completions=%0d want 10", tag, seen);
    else n_pass++;
    iREN = 0; dREN = 0; ram_ready = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    settle();
    n_checks++;
    if ({ramREN, ramWEN, iwait, dwait, ierr, derr} !== 6'b001100)
      $display("FAIL reset_flags: ren,wen,iwait,dwait,ierr,derr=%b want 001100",
               {ramREN, ramWEN, iwait, dwait, ierr, derr});
    else n_pass++;
    n_checks++;
    if (ramaddr !== '0 || ramstore !== '0)
      $display("FAIL reset_port: ramaddr=%h ramstore=%h want 0 0", ramaddr, ramstore);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_ifetch();
    apply_reset();
    iREN = 1; iaddr = 32'h40; ram_ready = 1; ramload = 32'hCAFE_0040;
    settle();
    n_checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1)
      $display("FAIL ifetch_c1: ramREN=%b iwait=%b want 0 1", ramREN, iwait);
    else n_pass++;
    next_cycle();
    settle();
    n_checks++;
    if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40)
      $display("FAIL ifetch_strobe: ren=%b wen=%b addr=%h want 1 0 40", ramREN, ramWEN, ramaddr);
    else n_pass++;
    n_checks++;
    if (iwait !== 1'b0 || dwait !== 1'b1 || iload !== 32'hCAFE_0040 || ierr !== 1'b0)
      $display("FAIL ifetch_done: iwait=%b dwait=%b iload=%h ierr=%b want 0 1 cafe0040 0",
               iwait, dwait, iload, ierr);
    else n_pass++;
    next_cycle();
    iREN = 0;
    settle();
    n_checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1)
      $display("FAIL ifetch_idle: ramREN=%b iwait=%b want 0 1", ramREN, iwait);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_priority();
    apply_reset();
    iREN = 1; iaddr = 32'h200;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    ram_ready = 1; ramload = 32'h5555_AAAA;
    settle();
    next_cycle();
    settle();
    n_checks++;
    if ({ramWEN, ramREN} !== 2'b10 || ramaddr !== 32'h100 || ramstore !== 32'hDEAD_BEEF)
      $display("FAIL prio_dwrite: wen,ren=%b%b addr=%h store=%h want 10 100 deadbeef",
               ramWEN, ramREN, ramaddr, ramstore);
    else n_pass++;
    n_checks++;
    if (dwait !== 1'b0 || iwait !== 1'b1 || derr !== 1'b0)
      $display("FAIL prio_dwait: dwait=%b iwait=%b derr=%b want 0 1 0", dwait, iwait, derr);
    else n_pass++;
    next_cycle();
    dWEN = 0;
    settle();
    n_checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011)
      $display("FAIL prio_gap: ren,wen,iwait,dwait=%b want 0011", {ramREN, ramWEN, iwait, dwait});
    else n_pass++;
    next_cycle();
    settle();
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b0 || iload !== 32'h5555_AAAA)
      $display("FAIL prio_ifetch: ren=%b addr=%h iwait=%b iload=%h want 1 200 0 5555aaaa",
               ramREN, ramaddr, iwait, iload);
    else n_pass++;
    next_cycle();
    iREN = 0; ram_ready = 0;
  endtask

  task automatic test_starvation();
    apply_reset();
    observe_contention("starve");
    next_cycle();
  endtask

  task automatic test_latency_hold();
    apply_reset();
    dREN = 1; daddr = 32'h80; dstore = 32'h1234_5678; ram_ready = 0;
    settle();
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      daddr = $urandom; dstore = $urandom; iREN = 1'($urandom_range(0, 1));
      ram_ready = (c == 5);
      settle();
      n_checks++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'h1234_5678)
        $display("FAIL hold_c%0d: ren=%b wen=%b addr=%h store=%h want 1 0 80 12345678",
                 c, ramREN, ramWEN, ramaddr, ramstore);
      else n_pass++;
      n_checks++;
      if (dwait !== (c != 5) || iwait !== 1'b1)
        $display("FAIL hold_wait_c%0d: dwait=%b iwait=%b want %b 1", c, dwait, iwait, c != 5);
      else n_pass++;
      next_cycle();
    end
    dREN = 0; iREN = 0; ram_ready = 0;
    settle();
    n_checks++;
    if (ramREN !== 1'b0 || dwait !== 1'b1)
      $display("FAIL hold_idle: ramREN=%b dwait=%b want 0 1", ramREN, dwait);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_error();
    apply_reset();
    iREN = 1; iaddr = 32'h44;
    settle();
    next_cycle();
    ram_error = 1;
    settle();
    n_checks++;
    if ({iwait, ierr, dwait, derr} !== 4'b0110)
      $display("FAIL err_flags: iwait,ierr,dwait,derr=%b want 0110", {iwait, ierr, dwait, derr});
    else n_pass++;
    next_cycle();
    iREN = 0; ram_error = 0;
    settle();
    n_checks++;
    if ({ramREN, iwait, ierr} !== 3'b010)
      $display("FAIL err_after: ren,iwait,ierr=%b want 010", {ramREN, iwait, ierr});
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    iREN = 1; dREN = 1; ram_ready = 1;
    repeat (6) begin
      settle();
      next_cycle();
    end
    ram_ready = 0;
    settle();
    next_cycle();
    settle();
    n_checks++;
    if (ramREN !== 1'b1) $display("FAIL rst_pre: ramREN=%b want 1", ramREN);
    else n_pass++;
    nRST = 0;
    #1;
    n_checks++;
    if ({ramREN, ramWEN, dwait, iwait} !== 4'b0011 || ramaddr !== '0)
      $display("FAIL rst_async: ren,wen,dwait,iwait=%b addr=%h want 0011 0",
               {ramREN, ramWEN, dwait, iwait}, ramaddr);
    else n_pass++;
    #2 nRST = 1;
    next_cycle();
    observe_contention("post_rst");
    next_cycle();
  endtask

  task automatic test_random();
    logic        i_pend = 0, d_pend = 0, d_wr = 0;
    logic [31:0] i_addr_r = '0, d_addr_r = '0, d_data_r = '0, r;
    int          owner = 0;          // 0 none, 1 instruction, 2 data
    int          lat_left = 0;
    int          d_wins_while_i_waits = 0;
    logic        fin, i_forced;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      r = $urandom;
      ram_mem[k] = r;
      ref_mem[k] = r;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc >= 600 && !i_pend && !d_pend && owner == 0) break;
      if (cyc < 600 && !i_pend && $urandom_range(0, 3) == 0) begin
        r = $urandom; i_pend = 1; i_addr_r = {r[31:2], 2'b00};
      end
      if (cyc < 600 && !d_pend && $urandom_range(0, 3) == 0) begin
        r = $urandom; d_pend = 1; d_wr = r[0]; d_addr_r = {r[31:2], 2'b00};
        d_data_r = $urandom;
      end
      iREN   = i_pend;
      iaddr  = i_pend ? i_addr_r : $urandom;
      dWEN   = d_pend && d_wr;
      dREN   = d_pend && (!d_wr || ($urandom_range(0, 1) == 1));
      daddr  = d_pend ? d_addr_r : $urandom;
      dstore = d_pend ? d_data_r : $urandom;
      fin = 0;
      if (owner != 0) begin
        lat_left--;
        fin = (lat_left == 0);
        ram_error = fin && ($urandom_range(0, 7) == 0);
        ram_ready = fin && (!ram_error || ($urandom_range(0, 1) == 1));
      end else begin
        ram_ready = 1'($urandom_range(0, 1));
        ram_error = ($urandom_range(0, 7) == 0);
      end
      ramload = ram_mem[ramaddr[5:2]];
      settle();
      n_checks++;
      case (owner)
        0: if ({ramREN, ramWEN, iwait, dwait, ierr, derr} !== 6'b001100) begin
             $display("FAIL rnd_idle cyc%0d: ren,wen,iwait,dwait,ierr,derr=%b want 001100",
                      cyc, {ramREN, ramWEN, iwait, dwait, ierr, derr});
           end else n_pass++;
        1: if ({ramREN, ramWEN, iwait, dwait, ierr, derr} !== {2'b10, !fin, 1'b1, fin && ram_error, 1'b0}
               || ramaddr !== i_addr_r) begin
             $display("FAIL rnd_iacc cyc%0d: flags=%b addr=%h want %b %h", cyc,
                      {ramREN, ramWEN, iwait, dwait, ierr, derr}, ramaddr,
                      {2'b10, !fin, 1'b1, fin && ram_error, 1'b0}, i_addr_r);
           end else n_pass++;
        default: if ({ramREN, ramWEN, iwait, dwait, ierr, derr} !== {!d_wr, d_wr, 1'b1, !fin, 1'b0, fin && ram_error}
               || ramaddr !== d_addr_r || (d_wr && ramstore !== d_data_r)) begin
             $display("FAIL rnd_dacc cyc%0d: flags=%b addr=%h store=%h want %b %h %h", cyc,
                      {ramREN, ramWEN, iwait, dwait, ierr, derr}, ramaddr, ramstore,
                      {!d_wr, d_wr, 1'b1, !fin, 1'b0, fin && ram_error}, d_addr_r, d_data_r);
           end else n_pass++;
      endcase
      if (fin && !ram_error && owner == 1) begin
        n_checks++;
        if (iload !== ref_mem[i_addr_r[5:2]])
          $display("FAIL rnd_iload cyc%0d: got %h want %h", cyc, iload, ref_mem[i_addr_r[5:2]]);
        else n_pass++;
      end
      if (fin && !ram_error && owner == 2 && !d_wr) begin
        n_checks++;
        if (dload !== ref_mem[d_addr_r[5:2]])
          $display("FAIL rnd_dload cyc%0d: got %h want %h", cyc, dload, ref_mem[d_addr_r[5:2]]);
        else n_pass++;
      end
      if (fin && !ram_error && owner == 2 && d_wr) begin
        if (ramWEN) ram_mem[ramaddr[5:2]] = ramstore;
        ref_mem[d_addr_r[5:2]] = d_data_r;
      end
      // Transaction model: completed requester withdraws; a free port grants at this edge.
      if (owner != 0 && fin) begin
        if (owner == 1) i_pend = 0; else d_pend = 0;
        owner = 0;
      end else if (owner == 0) begin
        i_forced = i_pend && (d_wins_while_i_waits >= STARVE_MAX);
        if (i_pend && (!d_pend || i_forced)) begin
          owner = 1;
          d_wins_while_i_waits = 0;
          lat_left = $urandom_range(1, 4);
        end else if (d_pend) begin
          owner = 2;
          d_wins_while_i_waits = i_pend ? d_wins_while_i_waits + 1 : 0;
          lat_left = $urandom_range(1, 4);
        end
      end
      next_cycle();
    end
    n_checks++;
    if (i_pend || d_pend || owner != 0)
      $display("FAIL rnd_drain: i_pend=%b d_pend=%b owner=%0d want all idle", i_pend, d_pend, owner);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    nRST = 1;
    test_reset();
    test_ifetch();
    test_priority();
    test_starvation();
    test_latency_hold();
    test_error();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
